rca_seq_ctrl: RTL and testbench
===============================

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 Parameter: SLICE_W, default 16, adder slice width in bits; legal values 8, 16, 32, 64; NBEATS = 64/SLICE_W.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset rst, synchronous, active-high; clock clk.
REQ-004 start  input  1  request a 64-bit addition; sampled each rising edge.
REQ-005 in1  input  64  operand A; sampled only on the edge that accepts start.
REQ-006 in2  input  64  operand B; sampled only on the edge that accepts start.
REQ-007 cin  input  1  carry-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  high while an addition is in progress (RUN state).
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum  output  64  registered result.
REQ-011 cout  output  1  registered carry-out of bit 63.
REQ-012 ovf  output  1  signed overflow flag; present only under REQ-030.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 -> capture in1/in2/cin, clear beat counter, go to RUN; start=0 -> stay.
REQ-015 RUN: each cycle adds slice k (bits k*SLICE_W+SLICE_W-1 : k*SLICE_W) of the captured operands plus the carry register, using one SLICE_W-bit ripple-carry adder instance.
REQ-016 RUN: slice result goes into a 64-bit accumulator at slice k; slice carry-out goes into the carry register; k increments by 1.
REQ-017 Carry register is loaded with the captured cin on accept; beat 0 uses it.
REQ-018 After beat NBEATS-1: load sum from the accumulator, load cout from the final carry, go to DONE.
REQ-019 Latency: done rises exactly NBEATS edges after the accepting edge (4 with SLICE_W=16); back-to-back throughput is one result per NBEATS+1 cycles.
REQ-020 DONE lasts one cycle with done=1, busy=0; start=1 in DONE is accepted (-> RUN), else -> IDLE.
REQ-021 start while in RUN is ignored; it is neither queued nor affects the captured operands.
REQ-022 Input changes after the accepting edge do not affect the result.
REQ-023 sum and cout change only on the edge that enters DONE; otherwise they hold the previous result.
REQ-024 Arithmetic is modulo 2^64; cout = bit 64 of in1+in2+cin.
REQ-025 The beat counter is ceil(log2(NBEATS)) bits wide (minimum 1) and does not wrap within an operation.

Reset
REQ-026 rst=1 on an edge -> state IDLE, counter 0, carry 0, accumulator 0, captured operands 0.
REQ-027 Outputs after reset: busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-028 rst overrides start on the same edge; a reset during RUN or DONE aborts the operation with no done pulse.
REQ-029 The first start is accepted on the first edge with rst=0.

Configuration
REQ-030 Macro RCA_SEQ_OVF_EN.
- Defined: ovf port exists; ovf = (in1[63]==in2[63]) && (sum[63]!=in1[63]) using the captured operands; it is registered with sum and reset to 0.
- Undefined: no ovf port and no overflow logic.

Verification
REQ-031 Reset/idle: hold rst 3 cycles, then idle 5 cycles -> sum=0, cout=0, busy=0, done never asserted.
REQ-032 Carry ripple across all slices: in1=64'hFFFF_FFFF_FFFF_FFFF, in2=0, cin=1 -> done on the 4th edge after accept; sum=0, cout=1.
REQ-033 Basic add with ignored start and operand changes: in1=64'h0000_0001_0000_FFFF, in2=1, cin=0; pulse start again mid-RUN; change in1 mid-RUN -> one done only; sum=64'h0000_0001_0001_0000, cout=0.
REQ-034 Back-to-back: hold start=1 with a new pair at each accept (5+7, then 64'h8000_0000_0000_0000 + 64'h8000_0000_0000_0000) -> done pulses 5 cycles apart; results 12/cout=0, then 0/cout=1 (ovf=1 if RCA_SEQ_OVF_EN is defined).
REQ-035 Reset mid-op: accept, assert rst at beat 2 -> no done; sum=0; a subsequent add of 3+4 gives 7.
REQ-036 Parameter sweep: repeat REQ-032 with SLICE_W=8, 32, 64 -> latency 8, 2, 1 edges with an identical result.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Sequential 64-bit adder that uses one SLICE_W-bit ripple-carry adder over 64/SLICE_W beats.
// Optional signed-overflow output is enabled with the RCA_SEQ_OVF_EN macro.

module rca_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int unsigned i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module rca_seq_ctrl #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] sum,
  output logic        cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);
  localparam int unsigned NBEATS = 64 / SLICE_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [63:0]        acc_q, acc_d;
  logic [63:0]        a_q, a_d;
  logic [63:0]        b_q, b_d;
  logic [63:0]        sum_q, sum_d;
  logic               cout_q, cout_d;
`ifdef RCA_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [6:0]         shamt;
  logic [SLICE_W-1:0] a_slice, b_slice, slice_sum;
  logic               slice_co;
  logic [63:0]        slice_mask;
  logic [63:0]        acc_ins;
  logic               last_beat;

  // Slice k sits at bit offset k*SLICE_W; the shift keeps the SLICE_W=64 case free of zero-width slices.
  assign shamt      = 7'(cnt_q) * 7'(SLICE_W);
  assign a_slice    = SLICE_W'(a_q >> shamt);
  assign b_slice    = SLICE_W'(b_q >> shamt);
  assign slice_mask = 64'({SLICE_W{1'b1}});
  assign acc_ins    = (acc_q & ~(slice_mask << shamt)) | (64'(slice_sum) << shamt);
  assign last_beat  = (cnt_q == CNT_W'(NBEATS - 1));

  rca_adder #(
    .W(SLICE_W)
  ) u_rca (
    .a (a_slice),
    .b (b_slice),
    .ci(carry_q),
    .s (slice_sum),
    .co(slice_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      RUN: begin
        acc_d   = acc_ins;
        carry_d = slice_co;
        if (last_beat) begin
          sum_d   = acc_ins;
          cout_d  = slice_co;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = (a_q[63] == b_q[63]) && (acc_ins[63] != a_q[63]);
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = start ? RUN : IDLE;
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: four instances (SLICE_W 16, 8, 32, 64) share stimulus
// and are compared every cycle against a latency/arithmetic reference model.
`timescale 1ns/1ps

module tb_rca_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic        cin = 1'b0;

  logic        busy_w [4];
  logic        done_w [4];
  logic [63:0] sum_w  [4];
  logic        cout_w [4];
  logic        ovf_w  [4];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          cyc     = 0;

  always #5 clk = ~clk;

`ifdef RCA_SEQ_OVF_EN
  `define OVF_CONN(i) , .ovf(ovf_w[i])
`else
  `define OVF_CONN(i)
`endif

  rca_seq_ctrl #(.SLICE_W(16)) u_dut16 (.clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .cin(cin), .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .cout(cout_w[0]) `OVF_CONN(0));
  rca_seq_ctrl #(.SLICE_W(8))  u_dut8  (.clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .cin(cin), .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .cout(cout_w[1]) `OVF_CONN(1));
  rca_seq_ctrl #(.SLICE_W(32)) u_dut32 (.clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .cin(cin), .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .cout(cout_w[2]) `OVF_CONN(2));
  rca_seq_ctrl #(.SLICE_W(64)) u_dut64 (.clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .cin(cin), .busy(busy_w[3]), .done(done_w[3]), .sum(sum_w[3]), .cout(cout_w[3]) `OVF_CONN(3));

  // Reference model: an accepted request completes exactly 64/SLICE_W edges later.
  int          lat      [4] = '{4, 8, 2, 1};
  int          rem      [4] = '{0, 0, 0, 0};
  logic [64:0] pend     [4];
  logic        pend_ovf [4];
  logic        m_done   [4] = '{0, 0, 0, 0};
  logic [63:0] m_sum    [4] = '{0, 0, 0, 0};
  logic        m_cout   [4] = '{0, 0, 0, 0};
  logic        m_ovf    [4] = '{0, 0, 0, 0};
  int          done_cyc [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        rem[i] = 0; m_done[i] = 1'b0; m_sum[i] = '0; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
      end else if (rem[i] > 0) begin
        rem[i]--;
        m_done[i] = (rem[i] == 0);
        if (rem[i] == 0) begin
          m_sum[i]  = pend[i][63:0];
          m_cout[i] = pend[i][64];
          m_ovf[i]  = pend_ovf[i];
        end
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          rem[i]      = lat[i];
          pend[i]     = {1'b0, in1} + {1'b0, in2} + {64'd0, cin};
          pend_ovf[i] = (in1[63] == in2[63]) && (pend[i][63] != in1[63]);
        end
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("busy%0d", i), 64'(busy_w[i]), 64'(rem[i] > 0));
      check_eq($sformatf("done%0d", i), 64'(done_w[i]), 64'(m_done[i]));
      check_eq($sformatf("sum%0d", i),  sum_w[i], m_sum[i]);
      check_eq($sformatf("cout%0d", i), 64'(cout_w[i]), 64'(m_cout[i]));
`ifdef RCA_SEQ_OVF_EN
      check_eq($sformatf("ovf%0d", i),  64'(ovf_w[i]), 64'(m_ovf[i]));
`endif
    end
    if (done_w[0] === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Reset then idle: nothing may complete.
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(5);
    check_eq("idle_sum", sum_w[0], 64'd0);

    // Carry ripples through every slice.
    in1 = 64'hFFFF_FFFF_FFFF_FFFF; in2 = '0; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0; in1 = '0; cin = 1'b0;
    run(10);
    check_eq("ripple_sum",  sum_w[0], 64'd0);
    check_eq("ripple_cout", 64'(cout_w[0]), 64'd1);

    // Basic add with start pulsed and operand changed mid-run.
    done_cyc.delete();
    in1 = 64'h0000_0001_0000_FFFF; in2 = 64'd1; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; in1 = 64'h1234_5678_9ABC_DEF0;
    step();
    start = 1'b0;
    run(10);
    check_eq("basic_sum",   sum_w[0], 64'h0000_0001_0001_0000);
    check_eq("basic_ndone", 64'(done_cyc.size()), 64'd1);

    // Back-to-back with start held.
    done_cyc.delete();
    in1 = 64'd5; in2 = 64'd7; start = 1'b1;
    step();
    in1 = 64'h8000_0000_0000_0000; in2 = 64'h8000_0000_0000_0000;
    run(4);
    check_eq("b2b_sum0", sum_w[0], 64'd12);
    start = 1'b1;
    run(5);
    start = 1'b0;
    check_eq("b2b_sum1",  sum_w[0], 64'd0);
    check_eq("b2b_cout1", 64'(cout_w[0]), 64'd1);
    run(10);
    if (done_cyc.size() >= 2) check_eq("b2b_gap", 64'(done_cyc[1] - done_cyc[0]), 64'd5);
    else check_eq("b2b_ndone", 64'(done_cyc.size()), 64'd2);

    // Reset in the middle of an operation.
    in1 = 64'hDEAD_BEEF_0000_0001; in2 = 64'h1111; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(6);
    check_eq("abort_sum", sum_w[0], 64'd0);
    in1 = 64'd3; in2 = 64'd4; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    run(10);
    check_eq("after_abort_sum", sum_w[0], 64'd7);

    // Randomized traffic, including all-ones operands and occasional resets.
    for (int k = 0; k < 400; k++) begin
      start = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 59) == 0);
      in1   = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      in2   = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
      cin   = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; start = 1'b0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
